mod_symbol_sequencer: RTL
=========================

Name: mod_symbol_sequencer

Overview:
- Symbol scheduler for the digital modulator's 4:1 carrier/level select mux.
- Accepts a serial bit stream over a valid/ready handshake and packs bits into 2-bit symbols, MSB first.
- Drives the mux select pair {sel1, sel0}, holding each symbol for a fixed number of clock cycles.
- Double-buffered so that consecutive symbols are emitted back-to-back; signals underrun when data runs out.

Parameters:
- SYM_CYCLES, 4: clock cycles per symbol; legal range 2..65535.
- IDLE_SEL, 2'b00: select value driven while idle or in reset.
- MAP_GRAY, 0: 0 = binary map {b1,b0}; 1 = Gray map {b1, b1^b0}.
- CNT_W, $clog2(SYM_CYCLES): symbol counter width; derived, not overridden.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run enable.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  sequencer accepts bit this cycle.
- sel1  out  1  mux select MSB.
- sel0  out  1  mux select LSB.
- sym_active  out  1  a data symbol is being driven.
- sym_strobe  out  1  one-cycle pulse on the first cycle of each symbol.
- underrun  out  1  one-cycle pulse when RUN ends because the hold register is empty.

Behaviour:
- Reset, with rst high on a clock edge:
  - {sel1,sel0}=IDLE_SEL; sym_active=0; sym_strobe=0; underrun=0.
  - Assembler bit count, hold_full and counter cleared; state=IDLE.
  - bit_ready forced 0 combinationally while rst=1.
- Reset mid-operation discards any partial pair, the held symbol and the current symbol.
- Handshake:
  - A bit transfers when bit_valid && bit_ready.
  - The first bit of a pair is b1, the second is b0.
  - bit_ready = enable && !(hold_full && asm_cnt==1 && !consume).
  - consume = the engine loads from hold this cycle.
  - The first bit of the next pair is always accepted while hold is full; only the second bit stalls.
- Pair completion: on the cycle the second bit transfers, the pair is written to hold. hold_full is visible the next cycle.
- Symbol engine states:
  - IDLE: outputs IDLE_SEL, sym_active=0. If enable && hold_full, then:
    - load map(hold) into the output register;
    - counter=SYM_CYCLES-1;
    - sym_strobe=1, sym_active=1;
    - clear hold_full;
    - go to RUN.
  - RUN: counter decrements each cycle. At counter==0:
    - If enable && hold_full: load the next symbol with no gap, counter reloads, strobe pulses, stay in RUN.
    - Else if !enable: go to IDLE, outputs IDLE_SEL, no underrun; hold is retained.
    - Else (hold empty): go to IDLE, outputs IDLE_SEL, underrun=1 for one cycle.
- Latency: second bit accepted in cycle N means the symbol appears on sel at cycle N+2 when starting from IDLE.
- Symbol duration is exactly SYM_CYCLES cycles; the symbol is never truncated by enable falling.
- Simultaneous events:
  - Hold consumed and a second bit arriving in the same cycle: the bit is accepted and hold is refilled in that cycle (hold_full stays 1).
- enable low:
  - No bits are accepted.
  - A partial pair is retained.
- Underrun never asserts from IDLE and never asserts in the cycle following reset.
- All outputs are registered except bit_ready.

Decomposition:
- Package mod_seq_pkg contains:
  - state enum {ST_IDLE, ST_RUN};
  - default IDLE_SEL constant;
  - function sym_map(pair, gray) returning the 2-bit select.
- Sub-module mod_bit_pair_assembler contains the shift register, asm_cnt, hold register, hold_full and the bit_ready logic.
- The top level contains the FSM, counter and output registers.
- The 4:1 mux is instantiated by the parent, not inside this block.

Test Plan:
- Reset: rst=1 for 3 cycles with bit_valid=1, bit_in=1 -> bit_ready=0, sel=00, sym_active=0, no strobe/underrun; state stays IDLE after release until a pair arrives.
- Single symbol, SYM_CYCLES=4, MAP_GRAY=0: bits 1,0 accepted at cycles 0,1 -> sel=10 and strobe at cycle 3; sel=10 through cycle 6; underrun=1 and sel=00 at cycle 7.
- Continuous stream, MAP_GRAY=1: pairs 11,01,00,10 with bit_valid held 1 -> sel 10,01,00,11 for 4 cycles each, contiguous, 4 strobes, no underrun; bit_ready low only while the second bit waits on a full hold.
- Enable drop: enable=0 mid-symbol with hold full -> current symbol completes all 4 cycles, then sel=IDLE_SEL, no underrun; enable=1 -> held symbol on sel one cycle later with strobe.
- Reset mid-RUN with one partial bit (1) pending: rst for 1 cycle -> next cycle sel=00, sym_active=0; then bits 0,1 -> sel=01 (the old partial bit is not used).
- Terminal-count collision: hold full, first bit already in, second bit valid exactly at counter==0 -> bit_ready=1, bit accepted, next symbol follows without gap.

Source files
------------

// File: rtl/mod_seq_pkg.sv
// Shared types and helpers for the symbol sequencer: engine states,
// default idle select value and the pair-to-select mapping.
package mod_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SEL_IDLE_DEFAULT = 2'b00;

  // Map a received bit pair {b1,b0} onto the mux select pair.
  // Binary passes the pair through; Gray keeps b1 and replaces b0 with b1^b0.
  function automatic logic [1:0] sym_map(input logic [1:0] pair, input logic gray);
    logic [1:0] sel;
    if (gray) begin
      sel = {pair[1], pair[1] ^ pair[0]};
    end else begin
      sel = pair;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mod_symbol_sequencer_if.sv
// Serial bit stream handshake into the symbol sequencer.
// master = bit source, slave = sequencer.
interface mod_symbol_sequencer_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/mod_bit_pair_assembler.sv
// Packs serial bits into 2-bit pairs (first bit = MSB) and keeps one
// completed pair in a hold register for the symbol engine.
module mod_bit_pair_assembler (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          consume,
  mod_symbol_sequencer_if.slave         bit_if,
  output logic                          hold_full,
  output logic [1:0]                    hold_pair
);

  logic       asm_cnt_q,   asm_cnt_d;
  logic       first_q,     first_d;
  logic [1:0] hold_q,      hold_d;
  logic       hold_full_q, hold_full_d;
  logic       ready;
  logic       accept;

  // Only the second bit of a pair can stall, and only when the hold
  // register is full and not being emptied this very cycle.
  assign ready            = !rst && enable && !(hold_full_q && asm_cnt_q && !consume);
  assign bit_if.bit_ready = ready;
  assign accept           = bit_if.bit_valid && ready;

  assign hold_full = hold_full_q;
  assign hold_pair = hold_q;

  // Next-state for the shift stage, pair counter and hold register.
  always_comb begin
    asm_cnt_d   = asm_cnt_q;
    first_d     = first_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (consume) begin
      hold_full_d = 1'b0;
    end
    // A completing pair refills hold even when it is consumed the same cycle.
    if (accept) begin
      if (!asm_cnt_q) begin
        first_d   = bit_if.bit_in;
        asm_cnt_d = 1'b1;
      end else begin
        hold_d      = {first_q, bit_if.bit_in};
        hold_full_d = 1'b1;
        asm_cnt_d   = 1'b0;
      end
    end
  end

  // Register update; reset drops any partial pair and the held pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_cnt_q   <= 1'b0;
      first_q     <= 1'b0;
      hold_q      <= 2'b00;
      hold_full_q <= 1'b0;
    end else begin
      asm_cnt_q   <= asm_cnt_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: rtl/mod_symbol_sequencer.sv
// Symbol scheduler for the modulator's 4:1 select mux: holds each 2-bit
// symbol on {sel1,sel0} for SYM_CYCLES clocks, back-to-back while data lasts.
module mod_symbol_sequencer
  import mod_seq_pkg::*;
#(
  parameter int          SYM_CYCLES = 4,
  parameter logic [1:0]  IDLE_SEL   = SEL_IDLE_DEFAULT,
  parameter bit          MAP_GRAY   = 1'b0,
  parameter int          CNT_W      = $clog2(SYM_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  mod_symbol_sequencer_if.slave bit_if,
  output logic                  sel1,
  output logic                  sel0,
  output logic                  sym_active,
  output logic                  sym_strobe,
  output logic                  underrun
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         sel_q,   sel_d;
  logic               active_q, active_d;
  logic               strobe_q, strobe_d;
  logic               underrun_q, underrun_d;
  logic               consume;
  logic               hold_full;
  logic [1:0]         hold_pair;

  mod_bit_pair_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .consume   (consume),
    .bit_if    (bit_if),
    .hold_full (hold_full),
    .hold_pair (hold_pair)
  );

  // Engine next-state: load from hold when idle or at terminal count,
  // otherwise count down and fall back to idle when the symbol ends.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    active_d   = active_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    consume    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sel_d    = IDLE_SEL;
        active_d = 1'b0;
        if (enable && hold_full) begin
          consume  = 1'b1;
          sel_d    = sym_map(hold_pair, MAP_GRAY);
          cnt_d    = CNT_W'(SYM_CYCLES - 1);
          strobe_d = 1'b1;
          active_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (enable && hold_full) begin
          consume  = 1'b1;
          sel_d    = sym_map(hold_pair, MAP_GRAY);
          cnt_d    = CNT_W'(SYM_CYCLES - 1);
          strobe_d = 1'b1;
          active_d = 1'b1;
        end else begin
          // Stopping because enable fell is not an underrun.
          sel_d      = IDLE_SEL;
          active_d   = 1'b0;
          underrun_d = enable;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = IDLE_SEL;
        active_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= IDLE_SEL;
      active_q   <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      active_q   <= active_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign {sel1, sel0} = sel_q;
  assign sym_active   = active_q;
  assign sym_strobe   = strobe_q;
  assign underrun     = underrun_q;

endmodule
